mips_div_sequencer: RTL and testbench

Iterative HI/LO divide controller for the MIPS core. It accepts DIV/DIVU operands from the execute stage and runs a 32-step restoring division using a shift/subtract datapath. It writes quotient to LO and remainder to HI, and holds `busy` high so the core can stall MFHI/MFLO until the result is ready. It also owns the HI/LO registers, so MTHI/MTLO writes go through it.

---
 rtl/mips_div_sequencer.sv | 146 ++++++++++++++
 tb/tb_mips_div_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_div_sequencer.sv
// mips_div_sequencer
//   Iterative HI/LO divide controller. Runs a WIDTH-step restoring division
//   (shift/subtract) for DIV/DIVU, writes quotient to LO and remainder to HI,
//   and owns the HI/LO registers so MTHI/MTLO writes are applied here too.
//
// Ports
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   start         divide request, sampled only in IDLE
//   is_signed     1 = DIV, 0 = DIVU (captured with start)
//   dividend      rs operand (captured with start)
//   divisor       rt operand (captured with start)
//   hi_we, lo_we  MTHI/MTLO strobes, applied in IDLE only
//   wdata         MTHI/MTLO write data
//   busy          divide in progress (state != IDLE)
//   done          one-cycle pulse after HI/LO are written by a divide
//   div_by_zero   sticky flag for the last divide, cleared by the next start
//   hi, lo        HI/LO registers
//
// Handshake: start is a level sampled on a rising edge while busy is low;
// a start seen while busy is dropped, never queued. done marks the cycle in
// which hi/lo first show the result; a start during that cycle is accepted.
module mips_div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem;       // partial remainder, one guard bit
  logic [WIDTH-1:0] quo;       // holds |dividend| at start, quotient at the end
  logic [WIDTH-1:0] dvsr;      // |divisor|
  logic [WIDTH-1:0] dvd_raw;   // untouched dividend, returned in HI on /0
  logic             q_neg;
  logic             r_neg;
  logic             dbz;
  logic             done_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;

  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;
  logic [WIDTH+1:0] diff;
  logic             borrow;

  // Negating 0x80000000 gives 0x80000000, which is the correct magnitude
  // when read as unsigned, so the most negative value needs no special case.
  assign dvd_abs = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign dvs_abs = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

  // Trial subtract of the shifted {rem, quo} against the divisor; the extra
  // top bit of diff is the borrow.
  assign diff   = {rem, quo[WIDTH-1]} - {2'b00, dvsr};
  assign borrow = diff[WIDTH+1];

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = (divisor == '0) ? FIX : ITER;
      ITER: if (cnt == LAST) state_nx = FIX;
      FIX:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      dvsr    <= '0;
      dvd_raw <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      dbz     <= 1'b0;
      done_r  <= 1'b0;
      hi_r    <= '0;
      lo_r    <= '0;
    end else begin
      done_r <= (state == FIX);
      case (state)
        IDLE: begin
          // An MTHI/MTLO on the accepting edge still lands; FIX overwrites it.
          if (hi_we) hi_r <= wdata;
          if (lo_we) lo_r <= wdata;
          if (start) begin
            dvd_raw <= dividend;
            quo     <= dvd_abs;
            dvsr    <= dvs_abs;
            rem     <= '0;
            q_neg   <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg   <= is_signed & dividend[WIDTH-1];
            dbz     <= (divisor == '0);
            cnt     <= '0;
          end
        end
        ITER: begin
          rem <= borrow ? {rem[WIDTH-1:0], quo[WIDTH-1]} : diff[WIDTH:0];
          quo <= {quo[WIDTH-2:0], ~borrow};
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          if (dbz) begin
            hi_r <= dvd_raw;
            lo_r <= '1;
          end else begin
            lo_r <= q_neg ? -quo : quo;
            hi_r <= r_neg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign done        = done_r;
  assign div_by_zero = dbz;
  assign hi          = hi_r;
  assign lo          = lo_r;

endmodule

// File: tb/tb_mips_div_sequencer.sv
// Testbench for mips_div_sequencer: directed divides whose expected
// {div_by_zero, hi, lo} are queued at issue time and checked by a monitor on
// every done pulse; busy/latency/MTHI/MTLO/reset checks run inline.
module tb_mips_div_sequencer;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         hi_we;
  logic         lo_we;
  logic [W-1:0] wdata;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  logic [2*W:0] exp_q[$];

  int checks;
  int errors;
  int mon_checks;
  int mon_errors;
  int total_checks;
  int total_errors;

  mips_div_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .hi_we(hi_we), .lo_we(lo_we),
    .wdata(wdata), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- monitor / scoreboard ----------------
  logic done_prev;
  always @(negedge clk) begin
    logic [2*W:0] e;
    if (!rst_n) begin
      done_prev <= 1'b0;
    end else begin
      done_prev <= done;
      if (done) begin
        mon_checks++;
        if (done_prev) begin
          mon_errors++;
          $display("FAIL done_pulse: got done high on two cycles expected one");
        end
        if (exp_q.size() == 0) begin
          mon_errors++;
          $display("FAIL unexpected_done: got done with no queued result");
        end else begin
          e = exp_q.pop_front();
          mon_checks++;
          if (lo !== e[W-1:0]) begin
            mon_errors++;
            $display("FAIL result_lo: got %h expected %h", lo, e[W-1:0]);
          end
          mon_checks++;
          if (hi !== e[2*W-1:W]) begin
            mon_errors++;
            $display("FAIL result_hi: got %h expected %h", hi, e[2*W-1:W]);
          end
          mon_checks++;
          if (div_by_zero !== e[2*W]) begin
            mon_errors++;
            $display("FAIL result_dbz: got %b expected %b", div_by_zero, e[2*W]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drive start for one edge (E0); returns #1 after E0.
  task automatic start_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; is_signed = s; dividend = a; divisor = b;
    @(posedge clk);
    #1;
    start = 1'b0; dividend = '0; divisor = '0; is_signed = 1'b0;
  endtask

  task automatic push_exp(input logic dbz, input logic [W-1:0] h, input logic [W-1:0] l);
    exp_q.push_back({dbz, h, l});
  endtask

  // Waits up to 40 edges for done; exp_lat < 0 skips the latency check.
  task automatic wait_done(input int exp_lat, input string name);
    int k;
    k = 0;
    while (k < 40) begin
      @(posedge clk);
      #1;
      k++;
      if (done) break;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done in %0d cycles expected done", name, k);
    end else if (exp_lat >= 0) begin
      check({name, "_latency"}, W'(k), W'(exp_lat));
    end
  endtask

  task automatic run_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic dbz, input logic [W-1:0] h, input logic [W-1:0] l,
                         input int lat, input string name);
    push_exp(dbz, h, l);
    start_div(s, a, b);
    if (lat > 1) check({name, "_busy"}, W'(busy), W'(1));
    wait_done(lat, name);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks = 0; errors = 0; mon_checks = 0; mon_errors = 0;
    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", W'(busy), W'(0));
    check("reset_done", W'(done), W'(0));
    check("reset_dbz",  W'(div_by_zero), W'(0));
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // DIVU 100 / 7
    run_div(1'b0, 32'd100, 32'd7, 1'b0, 32'h2, 32'hE, 33, "divu_100_7");
    @(posedge clk); #1;
    check("done_drops", W'(done), W'(0));
    check("hi_stable", hi, 32'h2);

    // Signed divides
    run_div(1'b1, 32'hFFFFFFF9, 32'h2, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, "div_m7_2");
    run_div(1'b1, 32'h7, 32'hFFFFFFFE, 1'b0, 32'h1, 32'hFFFFFFFD, 33, "div_7_m2");

    // Edge cases
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h80000000, 33, "div_ovf");
    run_div(1'b0, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h0, 32'hFFFFFFFF, 33, "divu_max_1");

    // Divide by zero, sticky flag, then cleared by the next start
    run_div(1'b0, 32'h1234, 32'h0, 1'b1, 32'h1234, 32'hFFFFFFFF, 1, "divu_by0");
    repeat (3) @(posedge clk); #1;
    check("dbz_sticky", W'(div_by_zero), W'(1));
    push_exp(1'b0, 32'hFFFFFFFE, 32'hFFFFFFF2);   // -100 / 7 = -14 rem -2
    start_div(1'b1, 32'hFFFFFF9C, 32'd7);
    check("dbz_cleared", W'(div_by_zero), W'(0));
    wait_done(33, "div_m100_7");

    // Interference: stray start at E5, MTHI at E10 are both dropped
    push_exp(1'b0, 32'd1, 32'd111);               // 1000 / 9 = 111 rem 1
    start_div(1'b0, 32'd1000, 32'd9);
    repeat (4) @(posedge clk);
    start_div(1'b0, 32'd50, 32'd5);               // lands on E5
    repeat (4) @(posedge clk);
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'hAAAA5555;
    @(posedge clk); #1;                           // E10
    hi_we = 1'b0; wdata = '0;
    wait_done(23, "interfere");
    repeat (2) @(posedge clk); #1;
    check("stray_start_busy", W'(busy), W'(0));

    // Idle MTLO, then idle MTHI+MTLO together
    @(negedge clk);
    lo_we = 1'b1; wdata = 32'h55AA55AA;
    @(posedge clk); #1;
    lo_we = 1'b0;
    check("mtlo_lo", lo, 32'h55AA55AA);
    check("mtlo_hi_kept", hi, 32'd1);
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0BADF00D;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    check("mt_both_hi", hi, 32'h0BADF00D);
    check("mt_both_lo", lo, 32'h0BADF00D);

    // Asynchronous reset in the middle of a divide
    start_div(1'b0, 32'd12345, 32'd6);
    repeat (15) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", W'(busy), W'(0));
    check("abort_done", W'(done), W'(0));
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_idle", W'(busy), W'(0));

    // Back-to-back: second start issued during the done cycle
    run_div(1'b0, 32'd100, 32'd10, 1'b0, 32'h0, 32'd10, 33, "b2b_first");
    push_exp(1'b0, 32'd2, 32'd4);                 // 30 / 7 = 4 rem 2
    start_div(1'b0, 32'd30, 32'd7);
    check("b2b_done_drop", W'(done), W'(0));
    check("b2b_busy", W'(busy), W'(1));
    wait_done(33, "b2b_second");

    repeat (3) @(posedge clk); #1;
    check("queue_empty", W'(exp_q.size()), W'(0));

    total_checks = checks + mon_checks;
    total_errors = errors + mon_errors;
    $display("CHECKS %0d ERRORS %0d", total_checks, total_errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
